game_life_ctrl: RTL and testbench



---
 rtl/game_life_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_game_life_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/game_life_ctrl.sv
// Character-life sequencer: sprite valids, missile lifetime/cooldown, respawns, lives, score.
// All outputs registered; responses appear one clock after the causing input, timing counted in tick pulses.
module game_life_ctrl #(
    parameter int unsigned LIVES           = 3,
    parameter int unsigned MISSILE_TICKS   = 12,
    parameter int unsigned CD_TICKS        = 4,
    parameter int unsigned D_RESPAWN_TICKS = 16,
    parameter int unsigned R_RESPAWN_TICKS = 8
) (
    input  logic       clk_25Hz,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       fire,
    input  logic [3:0] Event,
    output logic       d_valid,
    output logic       d1_valid,
    output logic       d2_valid,
    output logic       r_valid,
    output logic       m_valid,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic       game_over,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        R_DEAD = 2'd2,
        OVER   = 2'd3
    } state_t;

    localparam logic [1:0] LV = 2'(LIVES);
    localparam logic [7:0] MT = 8'(MISSILE_TICKS);
    localparam logic [7:0] CD = 8'(CD_TICKS);
    localparam logic [7:0] DR = 8'(D_RESPAWN_TICKS);
    localparam logic [7:0] RR = 8'(R_RESPAWN_TICKS);

    state_t     state_q, state_d;
    logic [2:0] dv_q, dv_d;            // [2]=d, [1]=d1, [0]=d2, same order as Event[3:1]
    logic       r_valid_q, r_valid_d;
    logic       m_valid_q, m_valid_d;
    logic [7:0] score_q, score_d;
    logic [1:0] lives_q, lives_d;
    logic       game_over_q, game_over_d;
    logic [7:0] m_cnt_q, m_cnt_d;
    logic [7:0] cd_q, cd_d;
    logic [7:0] d_cnt_q [3];
    logic [7:0] d_cnt_d [3];
    logic [7:0] r_cnt_q, r_cnt_d;
    logic [3:0] ev_q;

    logic [3:0] ev_rise;
    logic [2:0] kill;
    logic       r_rise;
    logic [1:0] n_kill;
    logic [8:0] score_sum;

    assign ev_rise   = Event & ~ev_q;
    assign kill      = ev_rise[3:1] & dv_q;
    assign r_rise    = ev_rise[0];
    assign n_kill    = {1'b0, kill[2]} + {1'b0, kill[1]} + {1'b0, kill[0]};
    assign score_sum = {1'b0, score_q} + {7'd0, n_kill};

    // Lower-priority effects are applied first so higher-priority ones overwrite them.
    always_comb begin
        state_d     = state_q;
        dv_d        = dv_q;
        r_valid_d   = r_valid_q;
        m_valid_d   = m_valid_q;
        score_d     = score_q;
        lives_d     = lives_q;
        game_over_d = game_over_q;
        m_cnt_d     = m_cnt_q;
        cd_d        = cd_q;
        r_cnt_d     = r_cnt_q;
        for (int i = 0; i < 3; i++) d_cnt_d[i] = d_cnt_q[i];

        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_d     = PLAY;
                    dv_d        = 3'b111;
                    r_valid_d   = 1'b1;
                    m_valid_d   = 1'b0;
                    score_d     = 8'd0;
                    lives_d     = LV;
                    game_over_d = 1'b0;
                    m_cnt_d     = 8'd0;
                    cd_d        = 8'd0;
                    r_cnt_d     = 8'd0;
                    for (int i = 0; i < 3; i++) d_cnt_d[i] = 8'd0;
                end
            end
            default: begin
                if (tick) begin
                    if (m_cnt_q != 8'd0) begin
                        m_cnt_d = m_cnt_q - 8'd1;
                        if (m_cnt_q == 8'd1) begin
                            m_valid_d = 1'b0;
                            cd_d      = CD;
                        end
                    end else if (cd_q != 8'd0) begin
                        cd_d = cd_q - 8'd1;
                    end
                    for (int i = 0; i < 3; i++) begin
                        if (d_cnt_q[i] != 8'd0) begin
                            d_cnt_d[i] = d_cnt_q[i] - 8'd1;
                            if (d_cnt_q[i] == 8'd1) dv_d[i] = 1'b1;
                        end
                    end
                    if (state_q == R_DEAD && r_cnt_q != 8'd0) begin
                        r_cnt_d = r_cnt_q - 8'd1;
                        if (r_cnt_q == 8'd1) begin
                            state_d   = PLAY;
                            r_valid_d = 1'b1;
                        end
                    end
                end

                if (state_q == PLAY) begin
                    if (fire && !m_valid_q && cd_q == 8'd0) begin
                        m_valid_d = 1'b1;
                        m_cnt_d   = MT;
                    end
                    if (kill != 3'b000) begin
                        for (int i = 0; i < 3; i++) begin
                            if (kill[i]) begin
                                dv_d[i]    = 1'b0;
                                d_cnt_d[i] = DR;
                            end
                        end
                        // A body collision kills the dragon but earns nothing.
                        if (!r_rise) begin
                            score_d   = (score_sum > 9'd255) ? 8'hFF : score_sum[7:0];
                            m_valid_d = 1'b0;
                            m_cnt_d   = 8'd0;
                            cd_d      = CD;
                        end
                    end
                    if (r_rise) begin
                        lives_d   = lives_q - 2'd1;
                        r_valid_d = 1'b0;
                        m_valid_d = 1'b0;
                        m_cnt_d   = 8'd0;
                        cd_d      = 8'd0;
                        if (lives_q == 2'd1) begin
                            state_d     = OVER;
                            game_over_d = 1'b1;
                            dv_d        = 3'b000;
                        end else begin
                            state_d = R_DEAD;
                            r_cnt_d = RR;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_25Hz) begin
        if (rst) begin
            state_q     <= IDLE;
            dv_q        <= 3'b000;
            r_valid_q   <= 1'b0;
            m_valid_q   <= 1'b0;
            score_q     <= 8'd0;
            lives_q     <= LV;
            game_over_q <= 1'b0;
            m_cnt_q     <= 8'd0;
            cd_q        <= 8'd0;
            r_cnt_q     <= 8'd0;
            ev_q        <= 4'd0;
            for (int i = 0; i < 3; i++) d_cnt_q[i] <= 8'd0;
        end else begin
            state_q     <= state_d;
            dv_q        <= dv_d;
            r_valid_q   <= r_valid_d;
            m_valid_q   <= m_valid_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            game_over_q <= game_over_d;
            m_cnt_q     <= m_cnt_d;
            cd_q        <= cd_d;
            r_cnt_q     <= r_cnt_d;
            ev_q        <= Event;
            for (int i = 0; i < 3; i++) d_cnt_q[i] <= d_cnt_d[i];
        end
    end

    assign d_valid   = dv_q[2];
    assign d1_valid  = dv_q[1];
    assign d2_valid  = dv_q[0];
    assign r_valid   = r_valid_q;
    assign m_valid   = m_valid_q;
    assign score     = score_q;
    assign lives     = lives_q;
    assign game_over = game_over_q;
    assign state     = state_q;

endmodule

// File: tb/tb_game_life_ctrl.sv
// Directed bench for game_life_ctrl: stimulus queues hand-computed expected outputs,
// a monitor pops one entry per clock and compares it against the registered outputs.
module tb_game_life_ctrl;

    logic       clk_25Hz = 1'b0;
    logic       rst = 1'b1, tick = 1'b0, start = 1'b0, fire = 1'b0;
    logic [3:0] Event = 4'd0;
    logic       d_valid, d1_valid, d2_valid, r_valid, m_valid, game_over;
    logic [7:0] score;
    logic [1:0] lives, state;

    game_life_ctrl dut (
        .clk_25Hz (clk_25Hz),
        .rst      (rst),
        .tick     (tick),
        .start    (start),
        .fire     (fire),
        .Event    (Event),
        .d_valid  (d_valid),
        .d1_valid (d1_valid),
        .d2_valid (d2_valid),
        .r_valid  (r_valid),
        .m_valid  (m_valid),
        .score    (score),
        .lives    (lives),
        .game_over(game_over),
        .state    (state)
    );

    initial forever #20 clk_25Hz = ~clk_25Hz;

    typedef struct packed {
        logic [1:0] st;
        logic [4:0] v;      // {d, d1, d2, r, m}
        logic [7:0] sc;
        logic [1:0] lv;
        logic       go;
    } obs_t;

    typedef struct {
        logic  chk;
        obs_t  o;
        string name;
    } ent_t;

    ent_t       sbq[$];
    int         checks = 0;
    int         errors = 0;
    obs_t       e;
    logic [3:0] ev_v = 4'd0;

    task automatic cyc(input logic r, input logic t, input logic s, input logic f,
                       input logic ch, input string nm);
        ent_t en;
        @(negedge clk_25Hz);
        rst = r; tick = t; start = s; fire = f; Event = ev_v;
        en.chk = ch; en.o = e; en.name = nm;
        sbq.push_back(en);
    endtask

    task automatic idle(input int n, input string nm);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, nm);
    endtask

    // Spaced ticks: proves counting follows tick pulses rather than clocks.
    task automatic ticks(input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, nm);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, nm);
        end
    endtask

    initial begin : monitor
        ent_t en;
        obs_t act;
        forever begin
            @(posedge clk_25Hz);
            #1;
            if (sbq.size() > 0) begin
                en  = sbq.pop_front();
                act = {state, d_valid, d1_valid, d2_valid, r_valid, m_valid, score, lives, game_over};
                if (en.chk) begin
                    checks++;
                    if (act !== en.o) begin
                        errors++;
                        $display("FAIL %s: got st=%0d v=%b sc=%0d lv=%0d go=%b, want st=%0d v=%b sc=%0d lv=%0d go=%b",
                                 en.name, act.st, act.v, act.sc, act.lv, act.go,
                                 en.o.st, en.o.v, en.o.sc, en.o.lv, en.o.go);
                    end
                end
            end
        end
    end

    initial begin : stim
        e = '0;
        e.lv = 2'd3;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "reset0");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "reset1");

        // IDLE ignores fire and Event
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "idle_fire");
        ev_v = 4'b1111;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "idle_event");
        ev_v = 4'b0000;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "idle_event_fall");

        e.st = 2'd1; e.v = 5'b11110;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "start");

        // Missile lifetime and cooldown
        e.v[0] = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "fire");
        ticks(11, "missile_hold");
        e.v[0] = 1'b0;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "missile_expire");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "fire_in_cd");
        ticks(3, "cd_run");
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "fire_on_last_cd_tick");
        e.v[0] = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "fire_after_cd");

        // Missile kill of d with Event held
        ev_v = 4'b1000;
        e.v[4] = 1'b0; e.v[0] = 1'b0; e.sc = 8'd1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "kill_d");
        idle(99, "held_event");
        ticks(15, "d_respawn_wait");
        e.v[4] = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "d_respawn");
        ev_v = 4'b0000;
        idle(1, "release_d");

        // Body collision with d1: life lost, no score
        ev_v = 4'b0101;
        e.v[3] = 1'b0; e.v[1] = 1'b0; e.lv = 2'd2; e.st = 2'd2;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "hit_with_d1");
        ev_v = 4'b0000;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "rdead_fire_ignored");
        ev_v = 4'b1000;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "rdead_event_ignored");
        ev_v = 4'b0000;
        ticks(7, "rdead_wait");
        e.st = 2'd1; e.v[1] = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "robot_respawn");
        ticks(7, "d1_wait");
        e.v[3] = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "d1_respawn");

        // Remaining lives down to game over
        ev_v = 4'b0001;
        e.lv = 2'd1; e.st = 2'd2; e.v[1] = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "hit2");
        ev_v = 4'b0000;
        ticks(7, "rdead2_wait");
        e.st = 2'd1; e.v[1] = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "respawn2");
        ev_v = 4'b0001;
        e.lv = 2'd0; e.st = 2'd3; e.go = 1'b1; e.v = 5'b00000;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "hit3_over");
        ev_v = 4'b0000;
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "over_fire_ignored");
        ev_v = 4'b1110;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "over_event_ignored");
        ev_v = 4'b0000;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "over_idle");
        e.st = 2'd1; e.v = 5'b11110; e.sc = 8'd0; e.lv = 2'd3; e.go = 1'b0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "restart");

        // Triple kill with tick and fire in the same cycle
        ev_v = 4'b1110;
        e.v[4:2] = 3'b000; e.sc = 8'd3;
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "triple_kill_tick_fire");
        ev_v = 4'b0000;
        ticks(15, "triple_wait");
        e.v[4:2] = 3'b111;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "triple_respawn");

        // Score saturation at 255
        for (int k = 0; k < 85; k++) begin
            ev_v = 4'b1110;
            e.v[4:2] = 3'b000;
            e.sc = (e.sc > 8'd252) ? 8'd255 : e.sc + 8'd3;
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "sat_kill");
            ev_v = 4'b0000;
            for (int j = 0; j < 15; j++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "");
            e.v[4:2] = 3'b111;
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "sat_respawn");
        end

        // Reset in the middle of a game
        e.v[0] = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "pre_reset_fire");
        e = '0; e.lv = 2'd3;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "midgame_reset");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "post_reset_idle");

        for (int w = 0; w < 10 && sbq.size() > 0; w++) @(posedge clk_25Hz);
        repeat (2) @(posedge clk_25Hz);
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
